// File: rtl/ros2_eth_pkg.sv
// ----------------------------------------------------------------------------
// ros2_eth_pkg
// Shared definitions for the ROS2 Ethernet/IP adapters (TX and RX side).
//   - IP_HDR_SIZE          : fixed IPv4 header length (no options), bytes
//   - IP_HDR_OFFSET_*      : byte offsets of each field inside the header
//   - IP_VER_IHL           : version 4, IHL 5 constant first header byte
//   - ST_* / rx_state_e    : RX adapter state encoding
// ----------------------------------------------------------------------------
package ros2_eth_pkg;

   localparam int          IP_HDR_SIZE   = 20;
   localparam logic [15:0] IP_HDR_SIZE_W = 16'd20;

   localparam logic [15:0] IP_HDR_OFFSET_VER_IHL = 16'd0;
   localparam logic [15:0] IP_HDR_OFFSET_TOS     = 16'd1;
   localparam logic [15:0] IP_HDR_OFFSET_LENGTH  = 16'd2;
   localparam logic [15:0] IP_HDR_OFFSET_ID      = 16'd4;
   localparam logic [15:0] IP_HDR_OFFSET_FRAG    = 16'd6;
   localparam logic [15:0] IP_HDR_OFFSET_TTL     = 16'd8;
   localparam logic [15:0] IP_HDR_OFFSET_PROTO   = 16'd9;
   localparam logic [15:0] IP_HDR_OFFSET_CSUM    = 16'd10;
   localparam logic [15:0] IP_HDR_OFFSET_SRC_IP  = 16'd12;
   localparam logic [15:0] IP_HDR_OFFSET_DST_IP  = 16'd16;
   localparam logic [15:0] IP_HDR_OFFSET_LAST    = 16'd19;

   localparam logic [7:0]  IP_VER_IHL = 8'h45;

   localparam logic [2:0]  ST_IDLE    = 3'd0;
   localparam logic [2:0]  ST_HDR     = 3'd1;
   localparam logic [2:0]  ST_PAYLOAD = 3'd2;
   localparam logic [2:0]  ST_PAD     = 3'd3;
   localparam logic [2:0]  ST_DROP    = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE    = ST_IDLE,
      S_HDR     = ST_HDR,
      S_PAYLOAD = ST_PAYLOAD,
      S_PAD     = ST_PAD,
      S_DROP    = ST_DROP
   } rx_state_e;

endpackage

// File: rtl/ros2_eth_rx_adapter.sv
// ----------------------------------------------------------------------------
// ros2_eth_rx_adapter
// Re-serialises a parsed IPv4 header plus its AXI-Stream payload into one flat
// byte stream (20 header bytes, then payload) for the ROS2 packet parser FIFO.
// The declared IP total length is enforced: short payloads are zero-padded,
// excess payload is discarded, headers declaring length < 20 are dropped
// together with their payload.
//
// Handshakes: a header is taken on a cycle with i_rx_hdr_valid & o_rx_hdr_ready,
// a payload beat on i_rx_payload_tvalid & o_rx_payload_tready, and a byte is
// written to the FIFO exactly on cycles where o_dout_wr_en is high.
//
// Ports
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_enable                  gate for accepting new headers
//   i_rx_hdr_valid/o_rx_hdr_ready and i_rx_ip_* header fields
//   i_rx_payload_t*/o_rx_payload_tready   8-bit payload stream
//   o_dout_data/o_dout_wr_en/i_dout_full_n FIFO write port
// ----------------------------------------------------------------------------
module ros2_eth_rx_adapter
   import ros2_eth_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_enable,
   input  logic        i_rx_hdr_valid,
   output logic        o_rx_hdr_ready,
   input  logic [5:0]  i_rx_ip_dscp,
   input  logic [1:0]  i_rx_ip_ecn,
   input  logic [15:0] i_rx_ip_length,
   input  logic [15:0] i_rx_ip_identification,
   input  logic [2:0]  i_rx_ip_flags,
   input  logic [12:0] i_rx_ip_fragment_offset,
   input  logic [7:0]  i_rx_ip_ttl,
   input  logic [7:0]  i_rx_ip_protocol,
   input  logic [15:0] i_rx_ip_header_checksum,
   input  logic [31:0] i_rx_ip_source_ip,
   input  logic [31:0] i_rx_ip_dest_ip,
   input  logic        i_rx_payload_tvalid,
   input  logic [7:0]  i_rx_payload_tdata,
   input  logic        i_rx_payload_tlast,
   output logic        o_rx_payload_tready,
   output logic [7:0]  o_dout_data,
   input  logic        i_dout_full_n,
   output logic        o_dout_wr_en
);

   rx_state_e   state_q, state_d;
   logic [15:0] offset_q;
   logic [15:0] len_q;

   logic [5:0]  dscp_q;
   logic [1:0]  ecn_q;
   logic [15:0] length_q;
   logic [15:0] id_q;
   logic [2:0]  flags_q;
   logic [12:0] frag_q;
   logic [7:0]  ttl_q;
   logic [7:0]  proto_q;
   logic [15:0] csum_q;
   logic [31:0] src_q;
   logic [31:0] dst_q;

   logic        hdr_fire;
   logic        offset_inc;
   logic        offset_clr;
   logic        pay_fire;
   logic [7:0]  hdr_byte;

   // Header byte selected by the current offset.
   always_comb begin
      hdr_byte = 8'h00;
      case (offset_q)
         IP_HDR_OFFSET_VER_IHL:       hdr_byte = IP_VER_IHL;
         IP_HDR_OFFSET_TOS:           hdr_byte = {dscp_q, ecn_q};
         IP_HDR_OFFSET_LENGTH:        hdr_byte = length_q[15:8];
         IP_HDR_OFFSET_LENGTH + 16'd1: hdr_byte = length_q[7:0];
         IP_HDR_OFFSET_ID:            hdr_byte = id_q[15:8];
         IP_HDR_OFFSET_ID + 16'd1:    hdr_byte = id_q[7:0];
         IP_HDR_OFFSET_FRAG:          hdr_byte = {flags_q, frag_q[12:8]};
         IP_HDR_OFFSET_FRAG + 16'd1:  hdr_byte = frag_q[7:0];
         IP_HDR_OFFSET_TTL:           hdr_byte = ttl_q;
         IP_HDR_OFFSET_PROTO:         hdr_byte = proto_q;
         IP_HDR_OFFSET_CSUM:          hdr_byte = csum_q[15:8];
         IP_HDR_OFFSET_CSUM + 16'd1:  hdr_byte = csum_q[7:0];
         IP_HDR_OFFSET_SRC_IP:        hdr_byte = src_q[31:24];
         IP_HDR_OFFSET_SRC_IP + 16'd1: hdr_byte = src_q[23:16];
         IP_HDR_OFFSET_SRC_IP + 16'd2: hdr_byte = src_q[15:8];
         IP_HDR_OFFSET_SRC_IP + 16'd3: hdr_byte = src_q[7:0];
         IP_HDR_OFFSET_DST_IP:        hdr_byte = dst_q[31:24];
         IP_HDR_OFFSET_DST_IP + 16'd1: hdr_byte = dst_q[23:16];
         IP_HDR_OFFSET_DST_IP + 16'd2: hdr_byte = dst_q[15:8];
         IP_HDR_OFFSET_DST_IP + 16'd3: hdr_byte = dst_q[7:0];
         default:                     hdr_byte = 8'h00;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d             = state_q;
      o_rx_hdr_ready      = 1'b0;
      o_rx_payload_tready = 1'b0;
      o_dout_wr_en        = 1'b0;
      o_dout_data         = 8'h00;
      hdr_fire            = 1'b0;
      offset_inc          = 1'b0;
      offset_clr          = 1'b0;
      pay_fire            = 1'b0;
      case (state_q)
         S_IDLE: begin
            o_rx_hdr_ready = i_enable;
            if (i_rx_hdr_valid && i_enable) begin
               hdr_fire = 1'b1;
               state_d  = (i_rx_ip_length >= IP_HDR_SIZE_W) ? S_HDR : S_DROP;
            end
         end
         S_HDR: begin
            o_dout_wr_en = i_dout_full_n;
            o_dout_data  = hdr_byte;
            if (i_dout_full_n) begin
               if (offset_q == IP_HDR_OFFSET_LAST) begin
                  offset_clr = 1'b1;
                  state_d    = (len_q == 16'd0) ? S_IDLE : S_PAYLOAD;
               end else begin
                  offset_inc = 1'b1;
               end
            end
            // A header-only packet has no payload to sink.
            if (!i_enable) state_d = (len_q == 16'd0) ? S_IDLE : S_DROP;
         end
         S_PAYLOAD: begin
            o_rx_payload_tready = i_dout_full_n;
            o_dout_data         = i_rx_payload_tdata;
            pay_fire            = i_rx_payload_tvalid & i_dout_full_n;
            o_dout_wr_en        = pay_fire;
            if (pay_fire) begin
               offset_inc = 1'b1;
               if (offset_q == len_q - 16'd1) begin
                  state_d = i_rx_payload_tlast ? S_IDLE : S_DROP;
               end else if (i_rx_payload_tlast) begin
                  state_d = S_PAD;
               end
            end
            // If tlast is consumed on this very edge there is nothing left to sink.
            if (!i_enable) state_d = (pay_fire && i_rx_payload_tlast) ? S_IDLE : S_DROP;
         end
         S_PAD: begin
            o_dout_wr_en = i_dout_full_n;
            if (i_dout_full_n) begin
               offset_inc = 1'b1;
               if (offset_q == len_q - 16'd1) state_d = S_IDLE;
            end
            // tlast was already consumed, so abandoning padding returns straight to IDLE.
            if (!i_enable) state_d = S_IDLE;
         end
         S_DROP: begin
            o_rx_payload_tready = 1'b1;
            if (i_rx_payload_tvalid && i_rx_payload_tlast) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         offset_q <= 16'd0;
         len_q    <= 16'd0;
         dscp_q   <= 6'd0;
         ecn_q    <= 2'd0;
         length_q <= 16'd0;
         id_q     <= 16'd0;
         flags_q  <= 3'd0;
         frag_q   <= 13'd0;
         ttl_q    <= 8'd0;
         proto_q  <= 8'd0;
         csum_q   <= 16'd0;
         src_q    <= 32'd0;
         dst_q    <= 32'd0;
      end else begin
         if (hdr_fire) begin
            offset_q <= 16'd0;
            len_q    <= i_rx_ip_length - IP_HDR_SIZE_W;
            dscp_q   <= i_rx_ip_dscp;
            ecn_q    <= i_rx_ip_ecn;
            length_q <= i_rx_ip_length;
            id_q     <= i_rx_ip_identification;
            flags_q  <= i_rx_ip_flags;
            frag_q   <= i_rx_ip_fragment_offset;
            ttl_q    <= i_rx_ip_ttl;
            proto_q  <= i_rx_ip_protocol;
            csum_q   <= i_rx_ip_header_checksum;
            src_q    <= i_rx_ip_source_ip;
            dst_q    <= i_rx_ip_dest_ip;
         end else if (offset_clr) begin
            offset_q <= 16'd0;
         end else if (offset_inc) begin
            offset_q <= offset_q + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_ros2_eth_rx_adapter.sv
module tb_ros2_eth_rx_adapter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b1;
  logic        hdr_valid = 1'b0;
  logic        hdr_ready;
  logic [5:0]  h_dscp = '0;
  logic [1:0]  h_ecn = '0;
  logic [15:0] h_length = '0;
  logic [15:0] h_id = '0;
  logic [2:0]  h_flags = '0;
  logic [12:0] h_frag = '0;
  logic [7:0]  h_ttl = '0;
  logic [7:0]  h_proto = '0;
  logic [15:0] h_csum = '0;
  logic [31:0] h_src = '0;
  logic [31:0] h_dst = '0;
  logic        tvalid = 1'b0;
  logic [7:0]  tdata = '0;
  logic        tlast = 1'b0;
  logic        tready;
  logic [7:0]  dout_data;
  logic        full_n = 1'b1;
  logic        dout_wr_en;

  ros2_eth_rx_adapter dut (
    .i_clk                   (clk),
    .i_rst_n                 (rst_n),
    .i_enable                (enable),
    .i_rx_hdr_valid          (hdr_valid),
    .o_rx_hdr_ready          (hdr_ready),
    .i_rx_ip_dscp            (h_dscp),
    .i_rx_ip_ecn             (h_ecn),
    .i_rx_ip_length          (h_length),
    .i_rx_ip_identification  (h_id),
    .i_rx_ip_flags           (h_flags),
    .i_rx_ip_fragment_offset (h_frag),
    .i_rx_ip_ttl             (h_ttl),
    .i_rx_ip_protocol        (h_proto),
    .i_rx_ip_header_checksum (h_csum),
    .i_rx_ip_source_ip       (h_src),
    .i_rx_ip_dest_ip         (h_dst),
    .i_rx_payload_tvalid     (tvalid),
    .i_rx_payload_tdata      (tdata),
    .i_rx_payload_tlast      (tlast),
    .o_rx_payload_tready     (tready),
    .o_dout_data             (dout_data),
    .i_dout_full_n           (full_n),
    .o_dout_wr_en            (dout_wr_en)
  );

  // ---------------- clock / reset / global state ----------------
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  int fn_mode = 0;       // 0: FIFO always has space, 1: random, 2: toggle
  int unsigned acc_cyc = 0;
  int unsigned idle_cyc = 0;

  logic [7:0] pay_q[$];  // payload beats offered for the current packet
  logic [7:0] exp_q[$];  // bytes the FIFO must receive
  logic [7:0] got_q[$];  // bytes the FIFO did receive

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // FIFO space pattern, changed just after each active edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (fn_mode)
        1:       full_n = 1'($urandom_range(0, 1));
        2:       full_n = ~full_n;
        default: full_n = 1'b1;
      endcase
    end
  end

  // Write-port monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (dout_wr_en === 1'b1) got_q.push_back(dout_data);
    end
  end

  // ---------------- reference model ----------------
  // Expected FIFO byte stream derived from the packet-level rules:
  // header image, then payload clipped or zero-extended to length-20.
  task automatic build_expected(input int length, input int nbeats);
    logic [159:0] hv;
    exp_q.delete();
    if (length < 20) return;
    hv = {8'h45, h_dscp, h_ecn, h_length, h_id, h_flags, h_frag,
          h_ttl, h_proto, h_csum, h_src, h_dst};
    for (int i = 0; i < 20; i++) exp_q.push_back(hv[159 - 8*i -: 8]);
    for (int i = 0; i < length - 20; i++)
      exp_q.push_back((i < nbeats) ? pay_q[i] : 8'h00);
  endtask

  // ---------------- drivers ----------------
  task automatic send_header();
    int budget;
    hdr_valid = 1'b1;
    budget = 0;
    forever begin
      @(negedge clk);
      if (hdr_ready === 1'b1) break;
      budget++;
      if (budget > 3000) begin
        check("hdr_accept_timeout", 32'd1, 32'd0);
        hdr_valid = 1'b0;
        return;
      end
    end
    acc_cyc = cyc;
    @(posedge clk);
    #1;
    hdr_valid = 1'b0;
  endtask

  task automatic send_payload(input int gap_pct);
    int budget;
    for (int i = 0; i < pay_q.size(); i++) begin
      while ($urandom_range(0, 99) < gap_pct) begin
        tvalid = 1'b0;
        @(posedge clk);
        #1;
      end
      tvalid = 1'b1;
      tdata  = pay_q[i];
      tlast  = (i == pay_q.size() - 1);
      budget = 0;
      forever begin
        @(negedge clk);
        if (tready === 1'b1) break;
        budget++;
        if (budget > 3000) begin
          check("beat_accept_timeout", 32'd1, 32'd0);
          tvalid = 1'b0;
          tlast  = 1'b0;
          return;
        end
      end
      @(posedge clk);
      #1;
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic set_fields(input bit fixed, input int length);
    h_length = 16'(length);
    if (fixed) begin
      h_dscp = 6'd0; h_ecn = 2'd0; h_id = 16'h1234; h_flags = 3'b010;
      h_frag = 13'd0; h_ttl = 8'd64; h_proto = 8'd17; h_csum = 16'hBEEF;
      h_src = 32'hC0A8_0001; h_dst = 32'hC0A8_0002;
    end else begin
      h_dscp = 6'($urandom); h_ecn = 2'($urandom); h_id = 16'($urandom);
      h_flags = 3'($urandom); h_frag = 13'($urandom); h_ttl = 8'($urandom);
      h_proto = 8'($urandom); h_csum = 16'($urandom);
      h_src = $urandom; h_dst = $urandom;
    end
  endtask

  task automatic fill_payload(input int nbeats, input bit counting);
    pay_q.delete();
    for (int i = 0; i < nbeats; i++)
      pay_q.push_back(counting ? 8'(i + 1) : 8'($urandom));
  endtask

  task automatic wait_idle(input string tag);
    int budget;
    budget = 0;
    forever begin
      @(negedge clk);
      if (hdr_ready === 1'b1) break;
      budget++;
      if (budget > 3000) begin
        check({tag, "_idle_timeout"}, 32'd1, 32'd0);
        break;
      end
    end
    idle_cyc = cyc;
  endtask

  task automatic compare_stream(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
  endtask

  // One packet end to end; optionally checks cycles from acceptance to IDLE.
  task automatic run_packet(input string tag, input int length, input int nbeats,
                            input int mode, input int gap, input bit fixed,
                            input int exp_lat);
    fn_mode = mode;
    set_fields(fixed, length);
    fill_payload(nbeats, fixed);
    build_expected(length, nbeats);
    got_q.delete();
    fork
      send_header();
      send_payload(gap);
    join
    wait_idle(tag);
    compare_stream(tag);
    if (exp_lat > 0) check({tag, "_latency"}, idle_cyc - acc_cyc, 32'(exp_lat));
    @(posedge clk);
    #1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int cnt;
    int len;
    int plen;
    int nb;
    int kind;

    // Reset values.
    enable = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_wr_en", dout_wr_en, 1'b0);
    check("rst_tready", tready, 1'b0);
    check("rst_dout", dout_data, 8'h00);
    check("rst_hdr_ready_en1", hdr_ready, 1'b1);
    enable = 1'b0;
    @(negedge clk);
    check("rst_hdr_ready_en0", hdr_ready, 1'b0);
    enable = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Exact payload: 28 writes, IDLE 29 cycles after acceptance.
    run_packet("len28", 28, 8, 0, 0, 1'b1, 29);
    if (got_q.size() >= 4) begin
      check("len28_b0", got_q[0], 8'h45);
      check("len28_b2", got_q[2], 8'h00);
      check("len28_b3", got_q[3], 8'h1C);
    end else begin
      check("len28_short", got_q.size(), 4);
    end

    // Header only; IDLE (and header acceptance) right after the 20th write.
    run_packet("len20", 20, 0, 0, 0, 1'b0, 21);

    // Early tlast: 4 data bytes then 6 zero bytes.
    run_packet("len30_pad", 30, 4, 0, 0, 1'b0, 31);

    // Excess payload: 4 forwarded, the other 6 sunk.
    run_packet("len24_trunc", 24, 10, 0, 0, 1'b0, 0);

    // Malformed header: nothing written, payload sunk to tlast.
    run_packet("len12_drop", 12, 6, 0, 0, 1'b0, 0);

    // Backpressure on every other cycle.
    run_packet("toggle_exact", 26, 6, 2, 20, 1'b0, 0);

    // Enable dropped mid-payload under toggling backpressure.
    fn_mode = 2;
    set_fields(1'b0, 60);
    fill_payload(40, 1'b0);
    build_expected(60, 40);
    got_q.delete();
    fork
      send_header();
      send_payload(0);
      begin
        repeat (60) @(posedge clk);
        #1;
        enable = 1'b0;
      end
    join
    cnt = got_q.size();
    check("en_hdr_complete", cnt >= 20, 1'b1);
    check("en_truncated", cnt < exp_q.size(), 1'b1);
    for (int i = 0; i < cnt && i < exp_q.size(); i++)
      check($sformatf("en_byte%0d", i), got_q[i], exp_q[i]);
    hdr_valid = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (hdr_ready === 1'b1) cnt++;
    end
    check("en_low_hdr_ready", cnt, 0);
    check("en_low_no_writes", got_q.size(), exp_q.size() > 0 ? got_q.size() : 0);
    @(posedge clk);
    #1;
    hdr_valid = 1'b0;
    enable = 1'b1;
    @(negedge clk);
    check("en_back_idle", hdr_ready, 1'b1);
    @(posedge clk);
    #1;

    // Reset in the middle of a header.
    fn_mode = 0;
    set_fields(1'b0, 40);
    send_header();
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_wr_en", dout_wr_en, 1'b0);
    check("midrst_tready", tready, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Randomized packets.
    for (int p = 0; p < 14; p++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0: begin len = $urandom_range(0, 19); nb = $urandom_range(1, 5); end
        1: begin len = $urandom_range(20, 60); nb = len - 20; end
        2: begin plen = $urandom_range(2, 30); len = plen + 20; nb = $urandom_range(1, plen - 1); end
        default: begin plen = $urandom_range(1, 30); len = plen + 20; nb = plen + $urandom_range(1, 6); end
      endcase
      run_packet($sformatf("rnd%0d", p), len, nb, $urandom_range(0, 2),
                 $urandom_range(0, 30), 1'b0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
